// File: rtl/gray_rx_decoder.sv
// Receive side of a Gray-coded crossing: synchronises an asynchronous Gray word,
// decodes it to binary and classifies every change as +1, -1 or an illegal jump.
module gray_rx_decoder #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] g_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             step_up,
  output logic             step_dn,
  output logic             step_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] step_cnt
);

  localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {S_FILL, S_RUN} state_e;

  state_e             state_q, state_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]   sync_d [SYNC_STAGES];
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [WIDTH-1:0]   diff;
  logic               valid_q, valid_d;
  logic               up_q, up_d;
  logic               dn_q, dn_d;
  logic               err_q, err_d;
  logic               sticky_q, sticky_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               run;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // State register and all datapath flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FILL;
      fill_q   <= '0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
      bin_q    <= '0;
      valid_q  <= 1'b0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_d[i];
      end
      bin_q    <= bin_d;
      valid_q  <= valid_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state: wait SYNC_STAGES+1 edges so the synchroniser holds real samples
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    if (state_q == S_FILL) begin
      if (fill_q == FILL_W'(SYNC_STAGES)) begin
        state_d = S_RUN;
      end else begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  // Datapath, classification and event bookkeeping
  always_comb begin
    sync_d[0] = g_in;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
    bin_d   = gray2bin(sync_q[SYNC_STAGES-1]);
    diff    = bin_d - bin_q;
    run     = (state_q == S_RUN);
    valid_d = (state_d == S_RUN);
    up_d    = run && (diff == WIDTH'(1));
    dn_d    = run && (diff == {WIDTH{1'b1}});
    err_d   = run && (diff != '0) && !up_d && !dn_d;

    // A new event in the clear cycle wins over the clear
    sticky_d = sticky_q;
    if (err_d) begin
      sticky_d = 1'b1;
    end else if (err_clr) begin
      sticky_d = 1'b0;
    end

    cnt_d = cnt_q;
    if (up_d || dn_d) begin
      if (err_clr) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (err_clr) begin
      cnt_d = '0;
    end
  end

  assign bin_out    = bin_q;
  assign bin_valid  = valid_q;
  assign step_up    = up_q;
  assign step_dn    = dn_q;
  assign step_err   = err_q;
  assign err_sticky = sticky_q;
  assign step_cnt   = cnt_q;

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Directed bench for gray_rx_decoder (WIDTH=4, SYNC_STAGES=2, CNT_W=8).
module tb_gray_rx_decoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] g_in;
  logic       err_clr;
  logic [3:0] bin_out;
  logic       bin_valid;
  logic       step_up;
  logic       step_dn;
  logic       step_err;
  logic       err_sticky;
  logic [7:0] step_cnt;

  int vectors;
  int miscompares;
  int n_up, n_dn, n_err;

  gray_rx_decoder #(.WIDTH(4), .SYNC_STAGES(2), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .g_in       (g_in),
    .err_clr    (err_clr),
    .bin_out    (bin_out),
    .bin_valid  (bin_valid),
    .step_up    (step_up),
    .step_dn    (step_dn),
    .step_err   (step_err),
    .err_sticky (err_sticky),
    .step_cnt   (step_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] gray(input int v);
    logic [3:0] b;
    b = 4'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_count();
    tick();
    n_up  += int'(step_up);
    n_dn  += int'(step_dn);
    n_err += int'(step_err);
  endtask

  // Drive g, optionally raise err_clr on the edge where bin_out updates
  task automatic step(input string tag, input logic [3:0] g, input logic clr,
                      input logic [3:0] eb, input logic eu, input logic ed, input logic ee);
    g_in = g;
    tick();
    tick();
    err_clr = clr;
    tick();
    err_clr = 1'b0;
    chk({tag, "_bin"}, 32'(bin_out), 32'(eb));
    chk({tag, "_pulses"}, {29'd0, step_up, step_dn, step_err}, {29'd0, eu, ed, ee});
    tick();
    chk({tag, "_pulse_gone"}, {29'd0, step_up, step_dn, step_err}, 32'd0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; g_in = 4'b0000; err_clr = 1'b0;
    tick();
    tick();
    chk("reset_outs", {bin_out, bin_valid, step_up, step_dn, step_err, err_sticky, step_cnt}, 32'd0);

    // Fill after release
    rst_n = 1'b1;
    tick();
    chk("fill_e1_valid", 32'(bin_valid), 32'd0);
    tick();
    chk("fill_e2_valid", 32'(bin_valid), 32'd0);
    tick();
    chk("fill_e3_valid", 32'(bin_valid), 32'd1);
    chk("fill_e3_outs", {bin_out, step_up, step_dn, step_err, err_sticky, step_cnt}, 32'd0);

    // Latency: two edges from sampling edge to bin_out
    g_in = 4'b0001;
    tick();
    tick();
    chk("lat_early", {bin_out, step_up}, 32'd0);
    tick();
    chk("lat_bin", 32'(bin_out), 32'd1);
    chk("lat_up", 32'(step_up), 32'd1);
    chk("lat_cnt", 32'(step_cnt), 32'd1);
    tick();
    chk("lat_up_gone", 32'(step_up), 32'd0);

    // Back to 0 and clear before the wrap sweep
    step("back0", 4'b0000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    chk("back0_cnt", 32'(step_cnt), 32'd2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr0_cnt", 32'(step_cnt), 32'd0);

    // Up-count through the whole code with wrap 15->0
    n_up = 0; n_dn = 0; n_err = 0;
    for (int v = 1; v <= 16; v++) begin
      g_in = gray(v % 16);
      tick_count();
      tick_count();
      tick_count();
    end
    chk("wrap_ups", 32'(n_up), 32'd16);
    chk("wrap_dns_errs", 32'(n_dn + n_err), 32'd0);
    chk("wrap_cnt", 32'(step_cnt), 32'd16);
    chk("wrap_bin", 32'(bin_out), 32'd0);

    // Jump to bin 5 (illegal from 0), then clear
    step("to5", 4'b0111, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1);
    chk("to5_cnt", 32'(step_cnt), 32'd16);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr5", {step_cnt, err_sticky}, 32'd0);

    // Up, down, illegal jump
    step("up6", 4'b0101, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0);
    step("dn5", 4'b0111, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0);
    step("err14", 4'b1001, 1'b0, 4'd14, 1'b0, 1'b0, 1'b1);
    chk("err14_sticky", 32'(err_sticky), 32'd1);
    chk("err14_cnt", 32'(step_cnt), 32'd2);

    // Clear collisions
    step("col_up", 4'b1000, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0);
    chk("col_up_cnt", 32'(step_cnt), 32'd1);
    chk("col_up_sticky", 32'(err_sticky), 32'd0);
    step("col_err", 4'b0010, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
    chk("col_err_sticky", 32'(err_sticky), 32'd1);
    chk("col_err_cnt", 32'(step_cnt), 32'd0);
    step("up4", 4'b0110, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0);
    chk("up4_cnt", 32'(step_cnt), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_alone", {step_cnt, err_sticky}, 32'd0);

    // Build step_cnt=9, err_sticky=1
    for (int v = 5; v <= 13; v++) begin
      step("run9", gray(v), 1'b0, 4'(v), 1'b1, 1'b0, 1'b0);
    end
    step("err2", 4'b0011, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1);
    chk("pre_rst", {step_cnt, err_sticky}, {23'd0, 8'd9, 1'b1});

    // Async reset between edges
    #3;
    rst_n = 1'b0;
    g_in = 4'b1000;
    #1;
    chk("async_rst", {bin_out, bin_valid, step_up, step_dn, step_err, err_sticky, step_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rr_e1", {bin_out, bin_valid}, 32'd0);
    tick();
    chk("rr_e2", {bin_out, bin_valid}, 32'd0);
    tick();
    chk("rr_e3", {bin_out, bin_valid, step_up, step_dn, step_err}, {23'd0, 4'd15, 1'b1, 3'b000});
    tick();
    chk("rr_e4", {step_up, step_dn, step_err}, 32'd0);

    // Saturation of step_cnt: 260 legal steps toggling 15 <-> 0
    n_up = 0; n_dn = 0; n_err = 0;
    for (int k = 0; k < 260; k++) begin
      g_in = (k % 2 == 0) ? 4'b0000 : 4'b1000;
      tick_count();
      tick_count();
      tick_count();
    end
    chk("sat_cnt", 32'(step_cnt), 32'd255);
    chk("sat_ups", 32'(n_up), 32'd130);
    chk("sat_dns", 32'(n_dn), 32'd130);
    chk("sat_errs", 32'(n_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
